// File: rtl/pipeline_pkg.sv
// Shared fetch-stage definitions: default widths, reset fetch address and
// the fetch controller state encoding.
package pipeline_pkg;

    localparam int          DEF_ADDR_W   = 16;
    localparam int          DEF_INST_W   = 64;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched {instruction, pc} pairs.
// Flush empties it and wins over push/pop on the same edge.
module fetch_buf #(
    parameter int W = 80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    // A push into a full buffer is only legal when the head leaves on the same edge.
    assign do_pop  = pop_i && !flush_i && (count_q != 2'd0);
    assign do_push = push_i && !flush_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: sequential fetch from a one-cycle-latency
// instruction memory into a 2-deep buffer, with halt and redirect handling.
module imem_fetch_ctrl
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_ins,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int ENT_W = INST_W + ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        buf_count;
    logic [ENT_W-1:0]  buf_head;
    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occ_next;

    assign pop  = inst_valid && inst_ready;
    assign push = inflight_q && !redirect_valid;

    // Entries held after this edge, counting the read that lands now.
    assign occ_next = {1'b0, buf_count} - {2'b0, pop} + {2'b0, inflight_q};

    assign issue = (state_q == ST_RUN) && !halt && !redirect_valid && (occ_next < 3'd2);

    fetch_buf #(
        .W (ENT_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ({mem_ins, tag_q}),
        .pop_i       (pop),
        .count_o     (buf_count),
        .head_o      (buf_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d = redirect_addr;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            tag_d      = fetch_pc_q;
            inflight_d = 1'b1;
        end

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (!redirect_valid && (occ_next == 3'd2)) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (pop || redirect_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!halt) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign mem_addr   = fetch_pc_q;
    assign inst_valid = (buf_count != 2'd0);
    assign inst       = buf_head[ENT_W-1:ADDR_W];
    assign inst_pc    = buf_head[ADDR_W-1:0];

endmodule
